// File: rtl/puf_count_ctrl.sv
// puf_count_ctrl: measurement sequencer for the ring-oscillator PUF counter pair.
// Each request runs RESP_W measurements. A measurement clears both counters,
// enables them for WINDOW cycles, waits SETTLE_CYC cycles and then compares them.
// The comparison bits are packed into a response word, which is returned
// through a valid/ready handshake. Every output is registered.
module puf_count_ctrl #(
    parameter int                CHAL_W     = 8,
    parameter int                CNT_W      = 8,
    parameter int                RESP_W     = 4,
    parameter int                WINDOW     = 16,
    parameter int                SETTLE_CYC = 2,
    parameter logic [CNT_W-1:0]  START_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [CHAL_W-1:0] challenge,
    input  logic              abort,
    output logic              req_ready,
    output logic [CHAL_W-1:0] osc_sel,
    output logic              cnt_reset,
    output logic              cnt_enable,
    output logic [CNT_W-1:0]  cnt_start,
    input  logic [CNT_W-1:0]  cnt_a_out,
    input  logic [CNT_W-1:0]  cnt_b_out,
    output logic [RESP_W-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              tie,
    output logic              ovf
);

    localparam int IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_W - 1);
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COUNT   = 3'd2,
        SETTLE  = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [CHAL_W-1:0] chal, chal_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, idx_inc;
    logic [TMR_W-1:0]  timer, timer_nxt;

    logic              req_ready_nxt;
    logic [CHAL_W-1:0] osc_sel_nxt;
    logic              cnt_reset_nxt;
    logic              cnt_enable_nxt;
    logic [RESP_W-1:0] resp_nxt;
    logic              resp_valid_nxt;
    logic              tie_nxt;
    logic              ovf_nxt;

    assign cnt_start = START_VAL;
    assign idx_inc   = idx + 1'b1;

    // State register and registered outputs; reset forces the idle/reset values at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            chal       <= '0;
            idx        <= '0;
            timer      <= '0;
            req_ready  <= 1'b1;
            osc_sel    <= '0;
            cnt_reset  <= 1'b1;
            cnt_enable <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
            tie        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            chal       <= chal_nxt;
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            req_ready  <= req_ready_nxt;
            osc_sel    <= osc_sel_nxt;
            cnt_reset  <= cnt_reset_nxt;
            cnt_enable <= cnt_enable_nxt;
            resp       <= resp_nxt;
            resp_valid <= resp_valid_nxt;
            tie        <= tie_nxt;
            ovf        <= ovf_nxt;
        end
    end

    // Next-state logic and the output values that take effect with the new state
    always_comb begin
        state_nxt      = state;
        chal_nxt       = chal;
        idx_nxt        = idx;
        timer_nxt      = timer;
        req_ready_nxt  = req_ready;
        osc_sel_nxt    = osc_sel;
        cnt_reset_nxt  = cnt_reset;
        cnt_enable_nxt = cnt_enable;
        resp_nxt       = resp;
        resp_valid_nxt = resp_valid;
        tie_nxt        = tie;
        ovf_nxt        = ovf;

        case (state)
            IDLE: begin
                if (req && req_ready) begin
                    chal_nxt       = challenge;
                    idx_nxt        = '0;
                    resp_nxt       = '0;
                    tie_nxt        = 1'b0;
                    ovf_nxt        = 1'b0;
                    osc_sel_nxt    = challenge;
                    req_ready_nxt  = 1'b0;
                    cnt_reset_nxt  = 1'b1;
                    cnt_enable_nxt = 1'b0;
                    state_nxt      = CLEAR;
                end
            end

            CLEAR: begin
                timer_nxt      = '0;
                cnt_reset_nxt  = 1'b0;
                cnt_enable_nxt = 1'b1;
                state_nxt      = COUNT;
            end

            COUNT: begin
                // A counter reaching all-ones may have wrapped; flag it for this request
                if ((cnt_a_out == ALL_ONES) || (cnt_b_out == ALL_ONES)) begin
                    ovf_nxt = 1'b1;
                end
                if (timer == WIN_LAST) begin
                    timer_nxt      = '0;
                    cnt_enable_nxt = 1'b0;
                    state_nxt      = SETTLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            SETTLE: begin
                if (timer == SET_LAST) begin
                    timer_nxt = '0;
                    state_nxt = COMPARE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            COMPARE: begin
                resp_nxt[idx] = (cnt_a_out > cnt_b_out);
                if (cnt_a_out == cnt_b_out) begin
                    tie_nxt = 1'b1;
                end
                cnt_reset_nxt  = 1'b1;
                cnt_enable_nxt = 1'b0;
                if (idx == IDX_LAST) begin
                    resp_valid_nxt = 1'b1;
                    state_nxt      = DONE;
                end else begin
                    idx_nxt     = idx_inc;
                    osc_sel_nxt = chal + CHAL_W'(idx_inc);
                    state_nxt   = CLEAR;
                end
            end

            DONE: begin
                if (resp_valid && resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    req_ready_nxt  = 1'b1;
                    state_nxt      = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything else, including a completing DONE handshake
        if (abort && (state != IDLE)) begin
            state_nxt      = IDLE;
            idx_nxt        = '0;
            timer_nxt      = '0;
            req_ready_nxt  = 1'b1;
            cnt_reset_nxt  = 1'b1;
            cnt_enable_nxt = 1'b0;
            resp_valid_nxt = 1'b0;
            resp_nxt       = '0;
            tie_nxt        = 1'b0;
            ovf_nxt        = 1'b0;
        end
    end

endmodule

// File: tb/tb_puf_count_ctrl.sv
// tb_puf_count_ctrl: randomized bench for puf_count_ctrl. It plans the counter
// readings for each request and derives the expected response, tie and ovf
// directly from those readings. Phase timing is derived from the measurement
// period arithmetic.
module tb_puf_count_ctrl;

    localparam int CHAL_W     = 8;
    localparam int CNT_W      = 8;
    localparam int RESP_W     = 4;
    localparam int WINDOW     = 16;
    localparam int SETTLE_CYC = 2;
    localparam int P          = WINDOW + SETTLE_CYC + 2;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic [CHAL_W-1:0] challenge = '0;
    logic              abort = 1'b0;
    logic              req_ready;
    logic [CHAL_W-1:0] osc_sel;
    logic              cnt_reset;
    logic              cnt_enable;
    logic [CNT_W-1:0]  cnt_start;
    logic [CNT_W-1:0]  cnt_a_out = '0;
    logic [CNT_W-1:0]  cnt_b_out = '0;
    logic [RESP_W-1:0] resp;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              tie;
    logic              ovf;

    puf_count_ctrl #(
        .CHAL_W(CHAL_W), .CNT_W(CNT_W), .RESP_W(RESP_W),
        .WINDOW(WINDOW), .SETTLE_CYC(SETTLE_CYC), .START_VAL(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .challenge(challenge), .abort(abort),
        .req_ready(req_ready), .osc_sel(osc_sel), .cnt_reset(cnt_reset),
        .cnt_enable(cnt_enable), .cnt_start(cnt_start), .cnt_a_out(cnt_a_out),
        .cnt_b_out(cnt_b_out), .resp(resp), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .tie(tie), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Planned final readings and optional all-ones spike per measurement
    logic [CNT_W-1:0] pa [RESP_W];
    logic [CNT_W-1:0] pb [RESP_W];
    int               spk [RESP_W];
    int               spk_off [RESP_W];

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_plan();
        for (int k = 0; k < RESP_W; k++) begin
            int v;
            pa[k] = CNT_W'($urandom);
            pb[k] = (($urandom % 4) == 0) ? pa[k] : CNT_W'($urandom);
            v = $urandom % 4;
            spk[k] = (v == 1) ? 1 : ((v == 2) ? 2 : 0);
            spk_off[k] = $urandom_range(1, WINDOW);
        end
    endtask

    // Run one request; abort_cyc / rst_cyc >= 0 interrupt it at that cycle after accept
    task automatic run_req(input logic [CHAL_W-1:0] chal, input int abort_cyc,
                           input int rst_cyc, input int bp);
        logic [RESP_W-1:0] er;
        logic              et, eo;
        logic [CHAL_W-1:0] eosc;
        logic [3:0]        ectl;
        int                k, o;
        er = '0; et = 1'b0; eo = 1'b0;
        for (int m = 0; m < RESP_W; m++) begin
            er[m] = (pa[m] > pb[m]);
            if (pa[m] == pb[m]) et = 1'b1;
            if (spk[m] != 0) eo = 1'b1;
        end

        chk("idle_ready", req_ready, 1);
        req = 1'b1;
        challenge = chal;
        step();
        req = 1'b0;

        for (int c = 0; c < RESP_W * P; c++) begin
            k = c / P;
            o = c % P;
            if (o == 0)                          ectl = 4'b1000;
            else if (o <= WINDOW)                ectl = 4'b0100;
            else                                 ectl = 4'b0000;
            chk("ctrl{rst,en,vld,rdy}", {cnt_reset, cnt_enable, resp_valid, req_ready}, ectl);
            if (o == 0) begin
                eosc = chal + CHAL_W'(k);
                chk("osc_sel", osc_sel, eosc);
            end

            if (c == abort_cyc) begin
                abort = 1'b1;
                req = 1'b0;
                step();
                abort = 1'b0;
                chk("abort_ctrl", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1001);
                chk("abort_resp", {resp, tie, ovf}, 0);
                for (int i = 0; i < 6; i++) begin
                    step();
                    chk("abort_idle", {resp_valid, req_ready}, 2'b01);
                end
                return;
            end

            if (c == rst_cyc) begin
                req = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("arst_ctrl", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1001);
                chk("arst_vals", {osc_sel, resp, tie, ovf}, 0);
                @(posedge clk);
                @(posedge clk);
                #2 reset = 1'b1;
                step();
                chk("arst_idle", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1001);
                return;
            end

            // Drive counter readings for the phase the DUT is in this cycle
            if (o == 0 || o > WINDOW + SETTLE_CYC - 0 && o <= WINDOW + SETTLE_CYC) begin
                cnt_a_out = CNT_W'($urandom);
                cnt_b_out = CNT_W'($urandom);
            end else if (o <= WINDOW) begin
                cnt_a_out = CNT_W'($urandom_range(0, CMAX - 1));
                cnt_b_out = CNT_W'($urandom_range(0, CMAX - 1));
                if (spk[k] == 1 && o == spk_off[k]) cnt_a_out = CNT_W'(CMAX);
                if (spk[k] == 2 && o == spk_off[k]) cnt_b_out = CNT_W'(CMAX);
            end else if (o <= WINDOW + SETTLE_CYC) begin
                cnt_a_out = CNT_W'($urandom);
                cnt_b_out = CNT_W'($urandom);
            end else begin
                cnt_a_out = pa[k];
                cnt_b_out = pb[k];
            end
            // Requests and ready while busy must have no effect
            req = $urandom_range(0, 1) == 1;
            challenge = CHAL_W'($urandom);
            resp_ready = $urandom_range(0, 1) == 1;
            step();
        end
        req = 1'b0;

        chk("done_ctrl", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1010);
        chk("resp", resp, er);
        chk("tie", tie, et);
        chk("ovf", ovf, eo);

        resp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            req = (i == bp / 2);
            challenge = CHAL_W'($urandom);
            step();
            req = 1'b0;
            chk("bp_ctrl", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1010);
            chk("bp_resp", {resp, tie, ovf}, {er, et, eo});
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("ret_ctrl", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1001);
        chk("held_vals", {resp, tie, ovf}, {er, et, eo});
        step();
        chk("stay_idle", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        // Reset held low for two cycles
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ctrl", {cnt_reset, cnt_enable, resp_valid, req_ready}, 4'b1001);
        chk("rst_vals", {osc_sel, resp, tie, ovf}, 0);
        chk("cnt_start", cnt_start, 8'h00);
        #1 reset = 1'b1;
        step();

        // Basic response: expect 4'b0101
        pa[0] = 8'd40; pb[0] = 8'd30;
        pa[1] = 8'd30; pb[1] = 8'd40;
        pa[2] = 8'd40; pb[2] = 8'd30;
        pa[3] = 8'd30; pb[3] = 8'd40;
        for (int k = 0; k < RESP_W; k++) spk[k] = 0;
        run_req(8'h10, -1, -1, 0);

        // Tie on idx 1 and overflow during COUNT of idx 2, with backpressure
        rand_plan();
        for (int k = 0; k < RESP_W; k++) spk[k] = 0;
        pa[1] = 8'h55; pb[1] = 8'h55;
        pa[0] = 8'h01; pb[0] = 8'h02;
        pa[3] = 8'h90; pb[3] = 8'h10;
        spk[2] = 1; spk_off[2] = 5;
        run_req(CHAL_W'($urandom), -1, -1, 10);

        // Abort during COUNT of idx 1, then a normal request
        rand_plan();
        run_req(CHAL_W'($urandom), P + 3, -1, 0);
        rand_plan();
        run_req(CHAL_W'($urandom), -1, -1, 2);

        // Asynchronous reset in the middle of SETTLE, then a normal request
        rand_plan();
        run_req(CHAL_W'($urandom), -1, 2 * P + WINDOW + 1, 0);
        rand_plan();
        run_req(CHAL_W'($urandom), -1, -1, 0);

        // osc_sel wraps past all-ones
        rand_plan();
        run_req(8'hFE, -1, -1, 1);

        // Random requests
        for (int r = 0; r < 6; r++) begin
            rand_plan();
            run_req(CHAL_W'($urandom), -1, -1, $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/puf_count_ctrl.md
Name: puf_count_ctrl

Overview:
- Measurement sequencer for the ring-oscillator PUF counter pair: two `up_counter` instances (A and B) clocked by the oscillators selected through `osc_sel`.
- Per request it runs RESP_W measurements. Each measurement is: clear both counters to START_VAL, enable for a fixed window, settle, compare.
- Packs the comparison bits into a response word and hands it back through a valid/ready handshake.
- Sits between the challenge interface and the counter datapath.

Parameters:
- CHAL_W, 8, challenge width and `osc_sel` width
- CNT_W, 8, counter output width
- RESP_W, 4, response bits per request (≥1)
- WINDOW, 16, enable cycles per measurement (≥1)
- SETTLE_CYC, 2, cycles enable held low before compare (≥1)
- START_VAL, 8'h00, value driven on `cnt_start` (CNT_W bits)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  request strobe, accepted when req && req_ready
- challenge  in  CHAL_W  challenge, latched on accept
- abort  in  1  synchronous abort, return to IDLE
- req_ready  out  1  high only in IDLE
- osc_sel  out  CHAL_W  oscillator-pair select
- cnt_reset  out  1  active-high synchronous reset to both counters
- cnt_enable  out  1  enable to both counters
- cnt_start  out  CNT_W  counter load value, constant START_VAL
- cnt_a_out  in  CNT_W  counter A value
- cnt_b_out  in  CNT_W  counter B value
- resp  out  RESP_W  response word
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- tie  out  1  sticky per request: some measurement had A==B
- ovf  out  1  sticky per request: a counter read all-ones during COUNT

Behaviour:
- Reset (reset=0, async) values:
  - State = IDLE, req_ready=1.
  - cnt_reset=1, cnt_enable=0.
  - osc_sel=0, resp=0, resp_valid=0, tie=0, ovf=0.
  - Internal idx=0, timer=0.
- States: IDLE, CLEAR, COUNT, SETTLE, COMPARE, DONE. All outputs are registered.
- IDLE:
  - cnt_reset=1, cnt_enable=0.
  - On req && req_ready: latch challenge; clear idx, resp, tie and ovf; go to CLEAR.
- CLEAR (1 cycle):
  - osc_sel = latched_challenge + idx, modulo 2^CHAL_W.
  - cnt_reset=1, cnt_enable=0.
  - Next state is COUNT.
- COUNT (exactly WINDOW cycles):
  - cnt_reset=0, cnt_enable=1.
  - If cnt_a_out or cnt_b_out equals all-ones in any COUNT cycle, set ovf.
  - Counters wrap freely; the controller does not correct for wrap.
- SETTLE (exactly SETTLE_CYC cycles): cnt_enable=0, cnt_reset=0.
- COMPARE (1 cycle):
  - Unsigned compare; resp[idx] = (cnt_a_out > cnt_b_out).
  - If the counts are equal: the bit is 0 and tie is set.
  - If idx == RESP_W-1, go to DONE. Otherwise increment idx and go to CLEAR.
- DONE:
  - resp_valid=1, and resp, tie and ovf are held stable.
  - cnt_reset=1, cnt_enable=0.
  - On resp_valid && resp_ready: resp_valid drops on the next edge and state goes to IDLE.
  - resp, tie and ovf keep their values until the next accept.
- Latency:
  - resp_valid rises exactly RESP_W*(WINDOW+SETTLE_CYC+2) cycles after the accepting edge.
  - With default parameters this is 80 cycles.
  - req_ready rises again on the edge after the DONE handshake.
- req while not IDLE: ignored, with no queuing.
- abort:
  - Valid in any state other than IDLE; IDLE is unaffected.
  - Next edge goes to IDLE with cnt_reset=1, cnt_enable=0, resp_valid=0.
  - resp, tie and ovf are cleared.
  - abort has priority over resp_ready in DONE.
- Reset mid-operation: immediate return to reset values, with no response produced.

Test Plan:
- **Basic response:** reset low 2 cycles, release; req with challenge=8'h10; bench drives A=40/B=30 for idx 0,2 and A=30/B=40 for idx 1,3. Required: osc_sel = 10,11,12,13 in successive CLEARs; resp_valid at cycle 80; resp=4'b0101; tie=0; ovf=0.
- **Tie and overflow:** A==B=8'h55 for idx 1, and A=8'hFF during COUNT of idx 2. Required: resp[1]=0, tie=1, ovf=1.
- **Backpressure:** resp_ready=0 for 10 cycles after valid. Required: resp, resp_valid and req_ready=0 all stable for those cycles; a req pulse during that time is ignored; after ready, IDLE one cycle later.
- **Abort:** assert abort in COUNT of idx 1. Required: next cycle IDLE, cnt_enable=0, cnt_reset=1, resp=0, resp_valid never rises; a new req then completes normally.
- **Async reset mid-run:** drop reset mid-SETTLE, between clock edges. Required: outputs take reset values immediately, without waiting for a clock edge.
- **Wrap of osc_sel:** challenge=8'hFE. Required: osc_sel = FE, FF, 00, 01.
